// File: rtl/palette_rgb_gen2_if.sv
// CPU byte-write / readback bus and video lookup port of the parametrised palette.
// The owner of the palette connects through the slave modport.
interface palette_rgb_gen2_if #(
    parameter int IDX_W  = 5,
    parameter int CHAN_W = 4
);
    logic [IDX_W:0]    bus_addr;
    logic [7:0]        bus_wrdata;
    logic              bus_wren;
    logic [7:0]        bus_rddata;
    logic              busy;
    logic [IDX_W-1:0]  palidx;
    logic [CHAN_W-1:0] pal_r;
    logic [CHAN_W-1:0] pal_g;
    logic [CHAN_W-1:0] pal_b;

    modport master (
        output bus_addr, bus_wrdata, bus_wren, palidx,
        input  bus_rddata, busy, pal_r, pal_g, pal_b
    );

    modport slave (
        input  bus_addr, bus_wrdata, bus_wren, palidx,
        output bus_rddata, busy, pal_r, pal_g, pal_b
    );
endinterface

// File: rtl/palette_rgb_gen2.sv
// Parametrised colour palette: two-byte CPU writes via a holding latch, hardware clear after reset,
// registered video lookup. Define PALETTE_READBACK_EN to add the registered CPU readback path.
module palette_rgb_gen2 #(
    parameter int IDX_W  = 5,
    parameter int CHAN_W = 4
) (
    input logic             clk,
    input logic             reset,
    palette_rgb_gen2_if.slave bus
);
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int COLOR_W = 3 * CHAN_W;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t               state, state_next;
    logic [IDX_W-1:0]     clear_ptr, clear_ptr_next;
    logic [7:0]           latch, latch_next;
    logic                 busy_q;
    logic                 ram_we;
    logic [IDX_W-1:0]     ram_waddr;
    logic [COLOR_W-1:0]   ram_wdata;
    logic [COLOR_W-1:0]   mem [ENTRIES];
    logic [COLOR_W-1:0]   pal_q;
    logic [IDX_W-1:0]     bus_entry;

    assign bus_entry = bus.bus_addr[IDX_W:1];

    always_comb begin
        state_next     = state;
        clear_ptr_next = clear_ptr;
        latch_next     = latch;
        ram_we         = 1'b0;
        ram_waddr      = clear_ptr;
        ram_wdata      = '0;
        case (state)
            CLEAR: begin
                // CPU traffic is ignored entirely until every entry has been zeroed
                ram_we         = 1'b1;
                clear_ptr_next = clear_ptr + IDX_W'(1);
                if (clear_ptr == '1)
                    state_next = IDLE;
            end
            IDLE: begin
                if (bus.bus_wren) begin
                    if (bus.bus_addr[0]) begin
                        // High byte commits {high, latched low}; bits beyond the colour width fall away
                        ram_we    = 1'b1;
                        ram_waddr = bus_entry;
                        ram_wdata = COLOR_W'({bus.bus_wrdata, latch});
                    end else begin
                        latch_next = bus.bus_wrdata;
                    end
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            clear_ptr <= '0;
            latch     <= '0;
            busy_q    <= 1'b1;
        end else begin
            state     <= state_next;
            clear_ptr <= clear_ptr_next;
            latch     <= latch_next;
            busy_q    <= (state_next == CLEAR);
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_waddr] <= ram_wdata;
    end

    // Registered lookup reads the pre-edge contents, so a same-edge write shows up one sample later
    always_ff @(posedge clk) begin
        if (reset || state == CLEAR)
            pal_q <= '0;
        else
            pal_q <= mem[bus.palidx];
    end

    assign bus.pal_r = pal_q[CHAN_W-1:0];
    assign bus.pal_g = pal_q[2*CHAN_W-1:CHAN_W];
    assign bus.pal_b = pal_q[3*CHAN_W-1:2*CHAN_W];
    assign bus.busy  = busy_q;

`ifdef PALETTE_READBACK_EN
    logic [15:0] rd_word;
    logic [7:0]  rd_q;

    assign rd_word = 16'(mem[bus_entry]);

    always_ff @(posedge clk) begin
        if (reset || state == CLEAR)
            rd_q <= '0;
        else
            rd_q <= bus.bus_addr[0] ? rd_word[15:8] : rd_word[7:0];
    end

    assign bus.bus_rddata = rd_q;
`else
    assign bus.bus_rddata = 8'h00;
`endif
endmodule

// File: tb/tb_palette_rgb_gen2.sv
// Randomised self-checking bench for palette_rgb_gen2: a default instance (IDX_W=5, CHAN_W=4) and a
// small instance (IDX_W=3, CHAN_W=2) share bus stimulus and are compared every cycle to array models.
module tb_palette_rgb_gen2;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1;
    logic [5:0] t_addr;
    logic [7:0] t_wd;
    logic       t_wren;
    logic [4:0] t_idx;

`ifdef PALETTE_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    palette_rgb_gen2_if #(.IDX_W(5), .CHAN_W(4)) if0 ();
    palette_rgb_gen2_if #(.IDX_W(3), .CHAN_W(2)) if1 ();

    assign if0.bus_addr   = t_addr;
    assign if0.bus_wrdata = t_wd;
    assign if0.bus_wren   = t_wren;
    assign if0.palidx     = t_idx;
    assign if1.bus_addr   = t_addr[3:0];
    assign if1.bus_wrdata = t_wd;
    assign if1.bus_wren   = t_wren;
    assign if1.palidx     = t_idx[2:0];

    palette_rgb_gen2 #(.IDX_W(5), .CHAN_W(4)) u_big   (.clk(clk), .reset(rst0), .bus(if0));
    palette_rgb_gen2 #(.IDX_W(3), .CHAN_W(2)) u_small (.clk(clk), .reset(rst1), .bus(if1));

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a countdown of entries still to clear, a byte latch and a plain colour array per instance
    int ent[2] = '{32, 8};
    int cw[2]  = '{4, 2};
    int aw[2]  = '{6, 4};
    int m_mem[2][32];
    int m_latch[2];
    int m_left[2];
    int e_pal[2];
    int e_rd[2];
    int e_busy[2];

    always @(posedge clk) begin : model
        int a, ei, idx, cmask, col;
        bit rst;
        for (int k = 0; k < 2; k++) begin
            rst   = (k == 0) ? rst0 : rst1;
            a     = int'(t_addr) & ((1 << aw[k]) - 1);
            ei    = a >> 1;
            idx   = int'(t_idx) & (ent[k] - 1);
            cmask = (1 << (3 * cw[k])) - 1;
            if (rst) begin
                m_left[k]  = ent[k];
                m_latch[k] = 0;
                e_pal[k]   = 0;
                e_rd[k]    = 0;
            end else if (m_left[k] > 0) begin
                m_mem[k][ent[k] - m_left[k]] = 0;
                m_left[k]--;
                e_pal[k] = 0;
                e_rd[k]  = 0;
            end else begin
                e_pal[k] = m_mem[k][idx];
                col      = m_mem[k][ei];
                e_rd[k]  = RB ? (((a & 1) != 0) ? ((col >> 8) & 255) : (col & 255)) : 0;
                if (t_wren) begin
                    if ((a & 1) != 0)
                        m_mem[k][ei] = ((int'(t_wd) << 8) | m_latch[k]) & cmask;
                    else
                        m_latch[k] = int'(t_wd);
                end
            end
            e_busy[k] = (m_left[k] > 0) ? 1 : 0;
        end
    end

    always @(negedge clk) begin : compare
        logic [31:0] d_busy, d_r, d_g, d_b, d_rd;
        int msk;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                if (k == 0) begin
                    d_busy = 32'(if0.busy);  d_r = 32'(if0.pal_r); d_g = 32'(if0.pal_g);
                    d_b    = 32'(if0.pal_b); d_rd = 32'(if0.bus_rddata);
                end else begin
                    d_busy = 32'(if1.busy);  d_r = 32'(if1.pal_r); d_g = 32'(if1.pal_g);
                    d_b    = 32'(if1.pal_b); d_rd = 32'(if1.bus_rddata);
                end
                msk = (1 << cw[k]) - 1;
                check(k == 0 ? "busy0" : "busy1", d_busy, 32'(e_busy[k]));
                check(k == 0 ? "r0" : "r1", d_r, 32'(e_pal[k] & msk));
                check(k == 0 ? "g0" : "g1", d_g, 32'((e_pal[k] >> cw[k]) & msk));
                check(k == 0 ? "b0" : "b1", d_b, 32'((e_pal[k] >> (2 * cw[k])) & msk));
                check(k == 0 ? "rd0" : "rd1", d_rd, 32'(e_rd[k]));
            end
        end
    end

    // All drives happen on the falling edge; each returns on a falling edge
    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        t_addr = a; t_wd = d; t_wren = 1'b1;
        @(negedge clk);
        t_wren = 1'b0;
    endtask

    // Called on the falling edge right after reset release; counts falling edges with busy high
    task automatic wait_clear(input int k, input int want, input bit do_wr, input string nm);
        int n = 0;
        while (((k == 0) ? if0.busy : if1.busy) && n < 200) begin
            n++;
            if (do_wr) begin
                t_wren = 1'b1;
                t_addr = {5'd5, n[0]};
                t_wd   = 8'(8'hA5 + n);
            end
            @(negedge clk);
        end
        t_wren = 1'b0;
        check(nm, 32'(n), 32'(want));
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        t_addr = '0; t_wd = '0; t_wren = 1'b0; t_idx = '0;

        // 1: clear after reset, writes during clear dropped, everything reads zero
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 32'(if0.busy), 32'd1);
        check("rst_rgb", 32'({if0.pal_b, if0.pal_g, if0.pal_r}), 32'd0);
        rst0 = 1'b0; rst1 = 1'b0;
        wait_clear(0, 32, 1'b1, "clear_len");
        wr(6'h0D, 8'h00);
        t_idx = 5'd5;
        @(negedge clk);
        check("e5_after_clear", 32'({if0.pal_b, if0.pal_g, if0.pal_r}), 32'd0);
        t_idx = 5'd6;
        @(negedge clk);
        check("latch_dropped", 32'({if0.pal_b, if0.pal_g, if0.pal_r}), 32'd0);
        for (int i = 0; i < 32; i++) begin
            t_idx = 5'(i);
            @(negedge clk);
            check("sweep_zero", 32'({if0.pal_b, if0.pal_g, if0.pal_r}), 32'd0);
        end

        // 2: two-byte write
        wr(6'h0A, 8'hB3);
        wr(6'h0B, 8'h0C);
        check("model_e5", 32'(m_mem[0][5]), 32'hCB3);
        t_idx = 5'd5;
        @(negedge clk);
        check("t2_r", 32'(if0.pal_r), 32'h3);
        check("t2_g", 32'(if0.pal_g), 32'hB);
        check("t2_b", 32'(if0.pal_b), 32'hC);

        // 6: readback (or constant zero)
        t_addr = 6'h0A;
        @(negedge clk);
        check("rb_lo", 32'(if0.bus_rddata), RB ? 32'hB3 : 32'h00);
        t_addr = 6'h0B;
        @(negedge clk);
        check("rb_hi", 32'(if0.bus_rddata), RB ? 32'h0C : 32'h00);

        // 3: latch reuse and discarded high bits
        wr(6'h0F, 8'h07);
        t_idx = 5'd7;
        @(negedge clk);
        check("t3_rgb", 32'({if0.pal_b, if0.pal_g, if0.pal_r}), 32'h7B3);
        wr(6'h0F, 8'hF7);
        @(negedge clk);
        check("t3_hibits", 32'({if0.pal_b, if0.pal_g, if0.pal_r}), 32'h7B3);
        check("model_e7", 32'(m_mem[0][7]), 32'h7B3);

        // 4: read-during-write returns old data first
        t_idx = 5'd5;
        wr(6'h0A, 8'h12);
        t_addr = 6'h0B; t_wd = 8'h00; t_wren = 1'b1;
        @(negedge clk);
        t_wren = 1'b0;
        check("rdw_old", 32'({if0.pal_b, if0.pal_g, if0.pal_r}), 32'hCB3);
        @(negedge clk);
        check("rdw_new", 32'({if0.pal_b, if0.pal_g, if0.pal_r}), 32'h012);

        // 5: reset mid-clear restarts; small instance two-byte write
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_busy", 32'(if0.busy), 32'd1);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        wait_clear(0, 32, 1'b0, "restart_len");
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        repeat (3) @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        wait_clear(1, 8, 1'b0, "small_clear_len");
        wr(6'h00, 8'h2D);
        wr(6'h01, 8'h3F);
        t_idx = 5'd0;
        @(negedge clk);
        check("small_r", 32'(if1.pal_r), 32'd1);
        check("small_g", 32'(if1.pal_g), 32'd3);
        check("small_b", 32'(if1.pal_b), 32'd2);
        check("model_small_e0", 32'(m_mem[1][0]), 32'h2D);

        // Random traffic with occasional resets
        repeat (3000) begin
            t_wren = 1'($urandom_range(0, 1));
            t_addr = 6'($urandom);
            t_wd   = 8'($urandom);
            t_idx  = 5'($urandom);
            rst0   = ($urandom_range(0, 499) == 0);
            rst1   = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        rst0 = 1'b0; rst1 = 1'b0; t_wren = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
